// File: rtl/mem_link_port.sv
// Link stage behind the memory controller: serialises a 1..9 byte request LSB-first onto
// the TX byte channel, then gathers 0..4 response bytes from RX into a 32-bit word.
module mem_link_port #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        send_req,
    input  logic [71:0] send_data,
    input  logic [3:0]  send_len,
    input  logic [2:0]  exp_len,
    output logic        send_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        recv_valid,
    output logic [31:0] recv_data,
    output logic        recv_err,
    input  logic        recv_ack,
    output logic        rx_overrun
);

    localparam int unsigned TmoW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSend, StRecv, StHold} state_e;

    state_e            state_q, state_d;
    logic [71:0]       shreg_q, shreg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        exp_q, exp_d;
    logic [2:0]        rcnt_q, rcnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              send_ready_q, send_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic              recv_valid_q, recv_valid_d;
    logic [31:0]       recv_data_q, recv_data_d;
    logic              recv_err_q, recv_err_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        rcnt_d       = rcnt_q;
        tmo_d        = tmo_q;
        send_ready_d = send_ready_q;
        tx_valid_d   = tx_valid_q;
        recv_valid_d = recv_valid_q;
        recv_data_d  = recv_data_q;
        recv_err_d   = recv_err_q;
        // Any RX byte that cannot be captured this cycle is lost for good.
        overrun_d    = overrun_q | (rx_valid & (~rdy_in | (state_q != StRecv)));

        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (send_req && (send_len != 4'd0)) begin
                        shreg_d      = send_data;
                        cnt_d        = (send_len > 4'd9) ? 4'd9 : send_len;
                        exp_d        = (exp_len > 3'd4) ? 3'd4 : exp_len;
                        rcnt_d       = 3'd0;
                        tmo_d        = '0;
                        recv_data_d  = 32'd0;
                        recv_err_d   = 1'b0;
                        tx_valid_d   = 1'b1;
                        send_ready_d = 1'b0;
                        state_d      = StSend;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        shreg_d = shreg_q >> 8;
                        cnt_d   = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            tx_valid_d = 1'b0;
                            if (exp_q == 3'd0) begin
                                send_ready_d = 1'b1;
                                state_d      = StIdle;
                            end else begin
                                state_d = StRecv;
                            end
                        end
                    end
                end
                StRecv: begin
                    if (rx_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            if (rcnt_q == 3'(i)) begin
                                recv_data_d[8*i +: 8] = rx_byte;
                            end
                        end
                        rcnt_d = rcnt_q + 3'd1;
                        tmo_d  = '0;
                        if (rcnt_q + 3'd1 == exp_q) begin
                            recv_valid_d = 1'b1;
                            recv_err_d   = 1'b0;
                            state_d      = StHold;
                        end
                    end else if (TIMEOUT != 0) begin
                        tmo_d = tmo_q + TmoW'(1);
                        if (tmo_q + TmoW'(1) == TmoW'(TIMEOUT)) begin
                            recv_valid_d = 1'b1;
                            recv_err_d   = 1'b1;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (recv_ack) begin
                        recv_valid_d = 1'b0;
                        send_ready_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            shreg_q      <= 72'd0;
            cnt_q        <= 4'd0;
            exp_q        <= 3'd0;
            rcnt_q       <= 3'd0;
            tmo_q        <= '0;
            send_ready_q <= 1'b1;
            tx_valid_q   <= 1'b0;
            recv_valid_q <= 1'b0;
            recv_data_q  <= 32'd0;
            recv_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            rcnt_q       <= rcnt_d;
            tmo_q        <= tmo_d;
            send_ready_q <= send_ready_d;
            tx_valid_q   <= tx_valid_d;
            recv_valid_q <= recv_valid_d;
            recv_data_q  <= recv_data_d;
            recv_err_q   <= recv_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign send_ready = send_ready_q;
    assign tx_byte    = shreg_q[7:0];
    assign tx_valid   = tx_valid_q;
    assign recv_valid = recv_valid_q;
    assign recv_data  = recv_data_q;
    assign recv_err   = recv_err_q;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_mem_link_port.sv
// Bench for mem_link_port: queue-based model of TX bytes and response words, plus
// directed scenarios with literal expectations.
module tb_mem_link_port;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        send_req;
    logic [71:0] send_data;
    logic [3:0]  send_len;
    logic [2:0]  exp_len;
    logic        send_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        recv_valid;
    logic [31:0] recv_data;
    logic        recv_err;
    logic        recv_ack;
    logic        rx_overrun;
    logic        rx_stray;

    int          checks;
    int          errors;
    logic [7:0]  tx_q[$];
    logic [32:0] resp_q[$];
    logic        ov_model;
    logic        last_hold;
    logic [7:0]  last_byte;

    mem_link_port #(.TIMEOUT(8)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .send_req   (send_req),
        .send_data  (send_data),
        .send_len   (send_len),
        .exp_len    (exp_len),
        .send_ready (send_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .recv_valid (recv_valid),
        .recv_data  (recv_data),
        .recv_err   (recv_err),
        .recv_ack   (recv_ack),
        .rx_overrun (rx_overrun)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every transferred byte must be the next one the model expects,
    // a stalled byte must not change, each acked response must match, overrun is sticky.
    always @(negedge clk_in) begin
        chk("rx_overrun", {31'd0, rx_overrun}, {31'd0, rst_in ? 1'b0 : ov_model});
        if (rst_in) begin
            ov_model  <= 1'b0;
            last_hold <= 1'b0;
        end else begin
            if (last_hold) begin
                chk("tx_valid_held", {31'd0, tx_valid}, 32'd1);
                chk("tx_stable", {24'd0, tx_byte}, {24'd0, last_byte});
            end
            if (tx_valid && tx_ready && rdy_in) begin
                if (tx_q.size() == 0) chk("tx_extra", 32'd1, 32'd0);
                else chk("tx_byte", {24'd0, tx_byte}, {24'd0, tx_q.pop_front()});
                last_hold <= 1'b0;
            end else begin
                last_hold <= tx_valid;
                last_byte <= tx_byte;
            end
            if (recv_valid && recv_ack && rdy_in) begin
                if (resp_q.size() == 0) begin
                    chk("resp_extra", 32'd1, 32'd0);
                end else begin
                    chk("resp_data", recv_data, resp_q[0][31:0]);
                    chk("resp_err", {31'd0, recv_err}, {31'd0, resp_q[0][32]});
                    void'(resp_q.pop_front());
                end
            end
            ov_model <= ov_model | (rx_valid & rx_stray);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!send_ready && n < 100) begin
            step();
            n++;
        end
        if (!send_ready) chk("send_ready_wait", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [71:0] d, input logic [3:0] len, input logic [2:0] el);
        int nb;
        wait_ready();
        nb = (len > 4'd9) ? 9 : int'(len);
        for (int i = 0; i < nb; i++) tx_q.push_back(d[8*i +: 8]);
        send_data = d;
        send_len  = len;
        exp_len   = el;
        send_req  = 1'b1;
        step();
        send_req  = 1'b0;
    endtask

    task automatic wait_tx_empty();
        int n = 0;
        while (tx_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (tx_q.size() != 0) chk("tx_drain_wait", 32'd0, 32'd1);
    endtask

    task automatic rx(input logic [7:0] b, input logic stray);
        rx_byte  = b;
        rx_valid = 1'b1;
        rx_stray = stray;
        step();
        rx_valid = 1'b0;
        rx_stray = 1'b0;
    endtask

    task automatic ack_resp();
        int n = 0;
        while (!recv_valid && n < 100) begin
            step();
            n++;
        end
        if (!recv_valid) chk("recv_valid_wait", 32'd0, 32'd1);
        recv_ack = 1'b1;
        step();
        recv_ack = 1'b0;
        chk("recv_valid_after_ack", {31'd0, recv_valid}, 32'd0);
        chk("send_ready_after_ack", {31'd0, send_ready}, 32'd1);
    endtask

    logic [7:0] t1 [5];

    initial begin
        checks = 0; errors = 0;
        rst_in = 1'b1; rdy_in = 1'b1; send_req = 1'b0; send_data = 72'd0;
        send_len = 4'd0; exp_len = 3'd0; tx_ready = 1'b0; rx_byte = 8'd0;
        rx_valid = 1'b0; rx_stray = 1'b0; recv_ack = 1'b0;
        t1 = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h02};
        step(); step();
        chk("rst_send_ready", {31'd0, send_ready}, 32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_recv_valid", {31'd0, recv_valid}, 32'd0);
        chk("rst_recv_data", recv_data, 32'd0);
        chk("rst_recv_err", {31'd0, recv_err}, 32'd0);
        rst_in = 1'b0;
        step();

        // 5-byte request, no response, tx_ready held high.
        tx_ready = 1'b1;
        send(72'h02_0304_0506, 4'd5, 3'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t1_tx_valid", {31'd0, tx_valid}, 32'd1);
            chk("t1_tx_byte", {24'd0, tx_byte}, {24'd0, t1[i]});
            step();
        end
        chk("t1_tx_done", {31'd0, tx_valid}, 32'd0);
        chk("t1_send_ready", {31'd0, send_ready}, 32'd1);

        // Zero-length request is ignored.
        send_len = 4'd0; send_req = 1'b1;
        step();
        send_req = 1'b0;
        step();
        chk("len0_send_ready", {31'd0, send_ready}, 32'd1);
        chk("len0_tx_valid", {31'd0, tx_valid}, 32'd0);

        // 9 bytes with tx_ready toggling.
        send(72'hF9_E8D7_C6B5_A493_8271, 4'd9, 3'd0);
        for (int n = 0; n < 60 && tx_q.size() != 0; n++) begin
            tx_ready = ~tx_ready;
            step();
        end
        chk("t2_drained", tx_q.size(), 32'd0);
        tx_ready = 1'b1;
        step();

        // send_len 12 clamps to 9 bytes.
        send(72'h19_2837_4655_6473_8291, 4'hC, 3'd0);
        wait_tx_empty();
        chk("clamp_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("clamp_send_ready", {31'd0, send_ready}, 32'd1);

        // 4-byte response with gaps, held 10 cycles before ack.
        send(72'h5A, 4'd1, 3'd4);
        wait_tx_empty();
        rx(8'hAA, 1'b0); step(); step();
        rx(8'hBB, 1'b0); step();
        rx(8'hCC, 1'b0); step(); step(); step();
        chk("t3_not_early", {31'd0, recv_valid}, 32'd0);
        resp_q.push_back({1'b0, 32'hDDCCBBAA});
        rx(8'hDD, 1'b0);
        chk("t3_recv_valid", {31'd0, recv_valid}, 32'd1);
        chk("t3_recv_data", recv_data, 32'hDDCCBBAA);
        chk("t3_recv_err", {31'd0, recv_err}, 32'd0);
        repeat (10) step();
        chk("t3_hold_valid", {31'd0, recv_valid}, 32'd1);
        chk("t3_hold_data", recv_data, 32'hDDCCBBAA);
        ack_resp();

        // exp_len 7 clamps to 4.
        send(72'h33, 4'd1, 3'd7);
        wait_tx_empty();
        resp_q.push_back({1'b0, 32'h04030201});
        rx(8'h01, 1'b0); rx(8'h02, 1'b0); rx(8'h03, 1'b0); rx(8'h04, 1'b0);
        chk("expclamp_valid", {31'd0, recv_valid}, 32'd1);
        ack_resp();

        // Timeout after 8 silent cycles keeps the partial byte.
        send(72'h44, 4'd1, 3'd2);
        wait_tx_empty();
        resp_q.push_back({1'b1, 32'h00000011});
        rx(8'h11, 1'b0);
        repeat (7) step();
        chk("tmo_not_early", {31'd0, recv_valid}, 32'd0);
        step();
        chk("tmo_valid", {31'd0, recv_valid}, 32'd1);
        chk("tmo_err", {31'd0, recv_err}, 32'd1);
        chk("tmo_data", recv_data, 32'h00000011);
        ack_resp();

        // A byte landing on the timeout cycle wins over the timeout.
        send(72'h45, 4'd1, 3'd2);
        wait_tx_empty();
        resp_q.push_back({1'b0, 32'h00002211});
        rx(8'h11, 1'b0);
        repeat (7) step();
        rx(8'h22, 1'b0);
        chk("race_valid", {31'd0, recv_valid}, 32'd1);
        chk("race_err", {31'd0, recv_err}, 32'd0);
        ack_resp();

        // Stray RX in IDLE, then a 3-cycle freeze mid-SEND with another stray byte.
        rx(8'h99, 1'b1);
        step();
        chk("ovr_set", {31'd0, rx_overrun}, 32'd1);
        send(72'h4433_2211, 4'd4, 3'd0);
        chk("frz_first", {24'd0, tx_byte}, 32'h11);
        step();
        rdy_in = 1'b0;
        rx_byte = 8'h77; rx_valid = 1'b1; rx_stray = 1'b1;
        step();
        rx_valid = 1'b0; rx_stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("frz_tx_byte", {24'd0, tx_byte}, 32'h22);
            chk("frz_tx_valid", {31'd0, tx_valid}, 32'd1);
            if (i < 2) step();
        end
        rdy_in = 1'b1;
        wait_tx_empty();
        chk("frz_done", {31'd0, tx_valid}, 32'd0);
        chk("frz_ready", {31'd0, send_ready}, 32'd1);
        repeat (3) step();
        chk("ovr_sticky", {31'd0, rx_overrun}, 32'd1);

        // Reset mid-RECV after 2 of 4 bytes, then a normal transfer.
        send(72'h55, 4'd1, 3'd4);
        wait_tx_empty();
        rx(8'h01, 1'b0); rx(8'h02, 1'b0);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_send_ready", {31'd0, send_ready}, 32'd1);
        chk("mid_rst_recv_valid", {31'd0, recv_valid}, 32'd0);
        chk("mid_rst_recv_data", recv_data, 32'd0);
        chk("mid_rst_overrun", {31'd0, rx_overrun}, 32'd0);
        step();
        rst_in = 1'b0;
        step();
        send(72'h6655, 4'd2, 3'd1);
        wait_tx_empty();
        resp_q.push_back({1'b0, 32'h0000007E});
        rx(8'h7E, 1'b0);
        chk("post_rst_data", recv_data, 32'h0000007E);
        ack_resp();

        step();
        chk("tx_q_empty", tx_q.size(), 32'd0);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_link_port.md
Name: mem_link_port

Overview:
- Byte-level link stage directly downstream of the memory controller.
- Accepts one packed request (1..9 bytes) from the controller and serialises it LSB-byte-first onto a byte-wide TX channel toward the host link.
- Then collects the expected response bytes (0..4) from the RX channel, assembles them into a 32-bit word and hands that word back to the controller with a valid/ack handshake.

Parameters:
- TIMEOUT, 1023: max idle cycles between RX bytes while collecting a response; 0 disables the timeout.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global enable; when low, all state and outputs freeze
- send_req  input  1  controller presents a request this cycle
- send_data  input  72  request bytes; byte k = send_data[8k+7:8k]
- send_len  input  4  number of request bytes, 1..9
- exp_len  input  3  response bytes expected, 0..4
- send_ready  output  1  block can accept a request (controller "se")
- tx_byte  output  8  outgoing byte
- tx_valid  output  1  tx_byte valid
- tx_ready  input  1  link accepts tx_byte
- rx_byte  input  8  incoming byte
- rx_valid  input  1  one-cycle strobe per incoming byte; no backpressure
- recv_valid  output  1  response word available (controller "re")
- recv_data  output  32  response word, little-endian
- recv_err  output  1  qualifies recv_valid: response ended by timeout
- recv_ack  input  1  controller consumes response (controller "is_recving")
- rx_overrun  output  1  sticky: an RX byte arrived outside RECV

Behaviour:
- Reset: state IDLE.
  - All outputs 0, except send_ready = 1.
  - All counters, the shift register and recv_data cleared.
- rdy_in = 0: no state, counter or output changes. RX bytes strobed during freeze are dropped and set rx_overrun.
- FSM states: IDLE, SEND, RECV, HOLD. All outputs are registered.
- IDLE:
  - send_ready = 1.
  - On send_req with send_len != 0:
    - Latch send_data into the shift register.
    - Latch byte count = min(send_len, 9) and exp_len.
    - Clear recv_data, recv_err and the timeout counter.
    - Next cycle: SEND, tx_valid = 1, tx_byte = byte 0, send_ready = 0.
  - send_req with send_len = 0 is ignored: no latch, no transition.
- SEND:
  - tx_valid held at 1; tx_byte must not change until accepted.
  - On tx_ready: shift right 8 and decrement the count. The next byte is presented the following cycle, so throughput is 1 byte/cycle with tx_ready held high.
  - On acceptance of the last byte: tx_valid = 0 next cycle. Go to IDLE if exp_len = 0, otherwise RECV.
- RECV:
  - Each rx_valid writes rx_byte into recv_data byte index rcnt (0 first), increments rcnt and clears the timeout counter.
  - Bytes above exp_len stay 0.
  - When rcnt reaches exp_len: go to HOLD, with recv_valid = 1 the next cycle and recv_err = 0.
  - Timeout (TIMEOUT != 0): counter increments on every cycle without rx_valid. When it equals TIMEOUT, go to HOLD with recv_err = 1; recv_data keeps the partial bytes.
  - An rx_valid in the same cycle as the timeout is captured and the timeout is suppressed.
- HOLD:
  - recv_valid and recv_data held until recv_ack.
  - On recv_ack (recv_valid = 1): recv_valid = 0 next cycle, go to IDLE, send_ready = 1 next cycle.
  - recv_ack outside HOLD is ignored.
  - No new request is accepted in HOLD. rx_valid in HOLD or IDLE or SEND drops the byte and sets rx_overrun.
- Boundary cases:
  - send_len > 9 is clamped to 9.
  - exp_len > 4 is clamped to 4.
  - Reset asserted mid-SEND or mid-RECV returns immediately to the reset state; the partial transfer is discarded, and tx_valid drops asynchronously.
  - rx_overrun clears only on reset.

Test Plan:
- Request send_data = 72'h..._0203_0405_06, send_len = 5, exp_len = 0, tx_ready = 1 -> tx_byte 06, 05, 04, 03, 02 on 5 consecutive cycles starting 1 cycle after accept; send_ready = 1 again 1 cycle after the last byte.
- send_len = 9, tx_ready toggling 1/0 -> 9 bytes in order, tx_byte stable while tx_ready = 0, no byte duplicated or lost.
- send_len = 1, exp_len = 4, RX bytes AA, BB, CC, DD with gaps -> recv_valid = 1, recv_data = 32'hDDCCBBAA, recv_err = 0. Response held 10 cycles with no ack; ack -> IDLE next cycle.
- TIMEOUT = 8, exp_len = 2, only byte 11 received, then silence -> after 8 idle cycles recv_valid = 1, recv_err = 1, recv_data = 32'h00000011.
- rx_valid strobe while IDLE, plus rdy_in held low for 3 cycles during SEND -> rx_overrun = 1 and stays 1; state, tx_byte and count unchanged across the freeze, and the transfer completes correctly afterwards.
- rst_in pulsed mid-RECV after 2 of 4 bytes -> all outputs at reset values, send_ready = 1; a new request afterwards completes normally.
